// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
// Shared definitions for the PWM sequencer: the sequencer state encoding,
// the default count width with its all-ones terminal count, and the default
// duty step and post-reset duty used by the top level.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int WIDTH_DEF    = 10;
    localparam int CNT_MAX      = (1 << WIDTH_DEF) - 1;
    localparam int STEP_DEF     = 16;
    localparam int DUTY_RST_DEF = 512;

endpackage

// File: rtl/pwm_presc.sv
// pwm_presc
// Prescaler tick generator. Counts 0..PRESCALE-1 while enabled and flags a
// tick on the last value; clr holds the count at 0.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clr   in  hold the prescaler at 0
//   en    in  advance the prescaler
//   tick  out high while enabled and the prescaler sits on PRESCALE-1
module pwm_presc #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A one-bit counter is kept even for PRESCALE = 1 so the vector is legal.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_s;

    assign tick = en && !clr && (presc_r == LAST);

    // Next prescaler value: clear, wrap on the last value, or step.
    always_comb begin
        presc_s = presc_r;
        if (clr) begin
            presc_s = {PW{1'b0}};
        end else if (en) begin
            if (presc_r == LAST) begin
                presc_s = {PW{1'b0}};
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end else begin
            presc_s = presc_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_s;
        end
    end

endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl
// Sequencer for the registered PWM comparator: produces the sawtooth count
// (comparator n1) and the committed duty (comparator n2). Duty edits from
// inc/dec pulses or a parallel load land in a shadow register and are
// committed only at a period wrap, so every period is clean. Stopping always
// finishes the current period first.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   en                 1 = run, 0 = stop after the current period
//   inc, dec           single-cycle duty step pulses
//   load_valid         duty load offered, load_duty = value
//   load_ready         load accepted this cycle when high
//   cnt                sawtooth count
//   duty               committed duty (0 while idle)
//   period_end         one-cycle pulse on the cycle cnt wraps to 0
//   run                high while counting (RUN and DRAIN)
module pwm_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = 4,
    parameter int STEP     = STEP_DEF,
    parameter int DUTY_RST = DUTY_RST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_duty,
    output logic             load_ready,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] duty,
    output logic             period_end,
    output logic             run
);

    localparam logic [WIDTH-1:0] CNT_TOP    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] DUTY_RST_W = WIDTH'(DUTY_RST);
    localparam logic [WIDTH:0]   STEP_W     = (WIDTH + 1)'(STEP);

    // Saturating step up, evaluated one bit wider so it never wraps.
    function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] sum_s;
        sum_s = {1'b0, v} + STEP_W;
        if (sum_s > {1'b0, CNT_TOP}) begin
            return CNT_TOP;
        end else begin
            return sum_s[WIDTH-1:0];
        end
    endfunction

    // Saturating step down; the extra top bit is the borrow.
    function automatic logic [WIDTH-1:0] sat_dn(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] diff_s;
        diff_s = {1'b0, v} - STEP_W;
        if (diff_s[WIDTH]) begin
            return CNT_ZERO;
        end else begin
            return diff_s[WIDTH-1:0];
        end
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] duty_r, duty_s;
    logic [WIDTH-1:0] committed_r, committed_s;
    logic [WIDTH-1:0] shadow_r, shadow_s;
    logic             load_pend_r, load_pend_s;
    logic             period_end_r, period_end_s;
    logic             run_r, run_s;
    logic             load_ready_r, load_ready_s;
    logic             tick_s;
    logic             wrap_s;
    logic             accept_s;
    logic             idle_stay_s;

    pwm_presc #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (state_r == ST_IDLE),
        .en    (state_r != ST_IDLE),
        .tick  (tick_s)
    );

    assign wrap_s   = tick_s && (cnt_r == CNT_TOP);
    assign accept_s = load_valid && load_ready_r;

    // Sequencer next state, count and commit.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        committed_s  = committed_r;
        load_pend_s  = load_pend_r;
        period_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Idle edits reach the committed duty one cycle later.
                committed_s = shadow_r;
                load_pend_s = 1'b0;
                if (en) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_TOP;
                end
            end
            ST_RUN, ST_DRAIN: begin
                cnt_s = tick_s ? (cnt_r + WIDTH'(1)) : cnt_r;
                if (wrap_s) begin
                    period_end_s = 1'b1;
                    committed_s  = shadow_r;
                end else begin
                    committed_s = committed_r;
                end
                if (wrap_s && !en && (state_r == ST_DRAIN)) begin
                    state_s     = ST_IDLE;
                    load_pend_s = 1'b0;
                end else begin
                    state_s     = en ? ST_RUN : ST_DRAIN;
                    // A load taken on the wrap cycle belongs to the next
                    // period, so setting wins over the wrap clear.
                    load_pend_s = accept_s || (load_pend_r && !wrap_s);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = CNT_TOP;
                load_pend_s = 1'b0;
            end
        endcase
    end

    // Shadow duty update and registered output values.
    always_comb begin
        shadow_s = shadow_r;
        if (accept_s) begin
            shadow_s = load_duty;
        end else if (load_pend_r) begin
            shadow_s = shadow_r;
        end else if (inc && !dec) begin
            shadow_s = sat_up(shadow_r);
        end else if (dec && !inc) begin
            shadow_s = sat_dn(shadow_r);
        end else begin
            shadow_s = shadow_r;
        end
        // The cycle after a drain wrap still shows cnt = 0 with run high;
        // outputs drop only once the sequencer has settled in IDLE.
        idle_stay_s  = (state_r == ST_IDLE) && (state_s == ST_IDLE);
        duty_s       = idle_stay_s ? CNT_ZERO : committed_s;
        run_s        = !idle_stay_s;
        load_ready_s = !load_pend_s;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_TOP;
            duty_r       <= CNT_ZERO;
            committed_r  <= DUTY_RST_W;
            shadow_r     <= DUTY_RST_W;
            load_pend_r  <= 1'b0;
            period_end_r <= 1'b0;
            run_r        <= 1'b0;
            load_ready_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            duty_r       <= duty_s;
            committed_r  <= committed_s;
            shadow_r     <= shadow_s;
            load_pend_r  <= load_pend_s;
            period_end_r <= period_end_s;
            run_r        <= run_s;
            load_ready_r <= load_ready_s;
        end
    end

    assign cnt        = cnt_r;
    assign duty       = duty_r;
    assign period_end = period_end_r;
    assign run        = run_r;
    assign load_ready = load_ready_r;

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl
// Directed bench for pwm_ctrl with PRESCALE = 1 (one count per clock).
// Expected output vectors are queued as each step is driven and compared
// after the following rising edge.
module tb_pwm_ctrl;
    import pwm_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       en;
    logic       inc;
    logic       dec;
    logic       load_valid;
    logic [9:0] load_duty;
    logic       load_ready;
    logic [9:0] cnt;
    logic [9:0] duty;
    logic       period_end;
    logic       run;

    typedef struct {
        string      tag;
        logic [9:0] cnt;
        logic [9:0] duty;
        logic       pe;
        logic       run;
        logic       lr;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;
    int   pos;

    localparam logic [9:0] TOP = 10'(CNT_MAX);

    pwm_ctrl #(
        .WIDTH    (10),
        .PRESCALE (1),
        .STEP     (16),
        .DUTY_RST (512)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .inc        (inc),
        .dec        (dec),
        .load_valid (load_valid),
        .load_duty  (load_duty),
        .load_ready (load_ready),
        .cnt        (cnt),
        .duty       (duty),
        .period_end (period_end),
        .run        (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
        pos = (pos + n) % 1024;
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed %0d expected %0d", tag, fld, obs, expv);
        end
    endtask

    // Queue the expectation, clock once, then pop and compare all outputs.
    task automatic step(input string tag, input logic [9:0] c, input logic [9:0] d,
                        input logic pe, input logic r, input logic lr);
        exp_t e;
        e.tag = tag; e.cnt = c; e.duty = d; e.pe = pe; e.run = r; e.lr = lr;
        sb_q.push_back(e);
        tick();
        pos = int'(c);
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard observed empty expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            cmp(e.tag, "cnt",  cnt,  e.cnt);
            cmp(e.tag, "duty", duty, e.duty);
            cmp(e.tag, "period_end", {9'd0, period_end}, {9'd0, e.pe});
            cmp(e.tag, "run",  {9'd0, run},  {9'd0, e.run});
            cmp(e.tag, "load_ready", {9'd0, load_ready}, {9'd0, e.lr});
        end
    endtask

    // Run to cnt = all-ones, then check the wrap cycle.
    task automatic adv_wrap(input string tag, input logic [9:0] d);
        adv(1023 - pos);
        step(tag, 10'd0, d, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        checks = 0; errors = 0; pos = 0;
        reset = 1'b1; en = 1'b0; inc = 1'b0; dec = 1'b0;
        load_valid = 1'b0; load_duty = 10'd0;

        step("reset", TOP, 10'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step("idle", TOP, 10'd0, 1'b0, 1'b0, 1'b1);

        // Start and first period
        en = 1'b1;
        step("start", 10'd0, 10'd512, 1'b0, 1'b1, 1'b1);
        step("cnt1", 10'd1, 10'd512, 1'b0, 1'b1, 1'b1);
        adv(1021);
        step("cnt_top", TOP, 10'd512, 1'b0, 1'b1, 1'b1);
        step("wrap1", 10'd0, 10'd512, 1'b1, 1'b1, 1'b1);
        step("after_wrap", 10'd1, 10'd512, 1'b0, 1'b1, 1'b1);

        // Three inc pulses mid-period commit only at the wrap
        adv(99);
        inc = 1'b1; step("inc_a", 10'd101, 10'd512, 1'b0, 1'b1, 1'b1);
        inc = 1'b0; step("gap_a", 10'd102, 10'd512, 1'b0, 1'b1, 1'b1);
        inc = 1'b1; step("inc_b", 10'd103, 10'd512, 1'b0, 1'b1, 1'b1);
        inc = 1'b0; step("gap_b", 10'd104, 10'd512, 1'b0, 1'b1, 1'b1);
        inc = 1'b1; step("inc_c", 10'd105, 10'd512, 1'b0, 1'b1, 1'b1);
        inc = 1'b0;
        adv(1022 - pos);
        step("pre_wrap_inc", TOP, 10'd512, 1'b0, 1'b1, 1'b1);
        step("wrap_inc", 10'd0, 10'd560, 1'b1, 1'b1, 1'b1);

        // Saturation high: load 1020, inc while pending is dropped
        load_valid = 1'b1; load_duty = 10'd1020;
        step("ld1020", 10'd1, 10'd560, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0; inc = 1'b1;
        step("inc_ignored", 10'd2, 10'd560, 1'b0, 1'b1, 1'b0);
        inc = 1'b0;
        adv_wrap("wrap1020", 10'd1020);
        inc = 1'b1;
        step("inc_sat", 10'd1, 10'd1020, 1'b0, 1'b1, 1'b1);
        inc = 1'b0;
        adv_wrap("wrap_sat_hi", 10'd1023);

        // Saturation low: load 5 then dec
        load_valid = 1'b1; load_duty = 10'd5;
        step("ld5", 10'd1, 10'd1023, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        adv_wrap("wrap5", 10'd5);
        dec = 1'b1;
        step("dec_sat", 10'd1, 10'd5, 1'b0, 1'b1, 1'b1);
        dec = 1'b0;
        adv_wrap("wrap_sat_lo", 10'd0);

        // inc and dec together cancel
        inc = 1'b1; dec = 1'b1;
        step("incdec", 10'd1, 10'd0, 1'b0, 1'b1, 1'b1);
        inc = 1'b0; dec = 1'b0;
        adv_wrap("wrap_incdec", 10'd0);

        // Load handshake: second load held off until after the wrap
        load_valid = 1'b1; load_duty = 10'd100;
        step("ld100", 10'd1, 10'd0, 1'b0, 1'b1, 1'b0);
        load_duty = 10'd200;
        step("ld200_held", 10'd2, 10'd0, 1'b0, 1'b1, 1'b0);
        adv_wrap("wrap100", 10'd100);
        step("ld200_acc", 10'd1, 10'd100, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        adv_wrap("wrap200", 10'd200);

        // Drain: en falls at cnt 300, period completes then idle
        adv(300);
        en = 1'b0;
        step("drain", 10'd301, 10'd200, 1'b0, 1'b1, 1'b1);
        adv_wrap("drain_wrap", 10'd200);
        step("drain_idle", TOP, 10'd0, 1'b0, 1'b0, 1'b1);
        step("idle_hold", TOP, 10'd0, 1'b0, 1'b0, 1'b1);

        // Restart, then en re-raised during DRAIN keeps running
        en = 1'b1;
        step("restart", 10'd0, 10'd200, 1'b0, 1'b1, 1'b1);
        adv(299);
        en = 1'b0;
        step("drain2", 10'd300, 10'd200, 1'b0, 1'b1, 1'b1);
        adv(99);
        en = 1'b1;
        step("rerun", 10'd400, 10'd200, 1'b0, 1'b1, 1'b1);
        adv_wrap("wrap_rerun", 10'd200);
        step("no_gap", 10'd1, 10'd200, 1'b0, 1'b1, 1'b1);

        // Reset mid-period with a pending load
        adv(699 - pos);
        load_valid = 1'b1; load_duty = 10'd300;
        step("ld300", 10'd700, 10'd200, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0; reset = 1'b1;
        step("reset_mid", TOP, 10'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step("post_reset", 10'd0, 10'd512, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_ctrl.md
# pwm_ctrl

Sequencer for the 10-bit registered PWM comparator. It generates the free-running sawtooth count fed to the comparator's `n1` input and the duty value fed to `n2`. Duty changes come from button pulses or a parallel load, and are committed only at period boundaries so no glitched period is produced. It also starts and stops the PWM cleanly, always finishing the current period before going idle.

## Interface
- `WIDTH`, 10: count/duty width, matching the comparator.
- `PRESCALE`, 4: clk cycles per count step; must be ≥ 1.
- `STEP`, 16: duty increment/decrement per `inc`/`dec` pulse.
- `DUTY_RST`, 512: duty value after reset.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  level; 1 = run the PWM, 0 = stop at the end of the current period.
- `inc`  in  1  single-cycle pulse (already debounced); raise duty by STEP.
- `dec`  in  1  single-cycle pulse; lower duty by STEP.
- `load_valid`  in  1  a duty load is offered.
- `load_duty`  in  WIDTH  duty value to load.
- `load_ready`  out  1  block accepts a load this cycle.
- `cnt`  out  WIDTH  sawtooth count, to comparator `n1`.
- `duty`  out  WIDTH  committed duty, to comparator `n2`.
- `period_end`  out  1  one-cycle pulse when `cnt` wraps.
- `run`  out  1  high in RUN and DRAIN.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **Reset values:**
  - state = IDLE.
  - `cnt` = 2^WIDTH−1.
  - `duty` = 0; internal committed duty = `DUTY_RST`; shadow = `DUTY_RST`.
  - prescaler = 0, `period_end` = 0, `load_ready` = 1, `run` = 0, load_pend = 0.
- **IDLE:**
  - `cnt` is held at all-ones and `duty` is driven 0, so the comparator output is 0.
  - Shadow updates commit to the internal duty on the next cycle.
  - `en` = 1 → RUN. On entry, `cnt` = 0 and the prescaler = 0.
- **RUN:**
  - The prescaler counts 0..PRESCALE−1. A tick occurs when it equals PRESCALE−1.
  - On each tick, `cnt` increments modulo 2^WIDTH.
  - On the tick where `cnt` goes from all-ones to 0:
    - `period_end` = 1 for that cycle;
    - shadow → committed duty;
    - load_pend clears.
  - `duty` output = committed duty.
  - `en` = 0 → DRAIN.
- **DRAIN:**
  - Counting continues as in RUN.
  - `en` = 1 → back to RUN with no discontinuity.
  - At the wrap: commit as in RUN, then go to IDLE.
- **Shadow update priority**, evaluated every cycle:
  - **Load:** the handshake (`load_valid` & `load_ready`) has priority. Shadow ← `load_duty`, and load_pend is set in RUN/DRAIN.
  - **inc only:** shadow ← min(shadow+STEP, 2^WIDTH−1), saturating.
  - **dec only:** shadow ← max(shadow−STEP, 0), saturating.
  - **inc & dec together:** no change.
  - inc/dec arriving in the same cycle as an accepted load are dropped.
  - inc/dec are ignored while load_pend = 1.
- **`load_ready`** = !load_pend. At most one load is accepted per period in RUN/DRAIN. In IDLE it is always 1.
- **Arithmetic:** saturation is computed at WIDTH+1 bits; no wrap-around.
- **Reset mid-operation:** all registers return to reset values on the next edge, regardless of state.

## Timing
- **Output registration:** `cnt`, `duty`, `period_end`, `run` and `load_ready` are registered.
- **Period:** 2^WIDTH × PRESCALE clk cycles.
- **High time at the comparator:** (duty+1) × PRESCALE cycles, delayed one cycle by the comparator register.
- **IDLE → first count:** `en` sampled high at edge k gives `cnt` = 0 and `run` = 1 after edge k.
- **Commit latency:**
  - RUN/DRAIN: a shadow change appears on `duty` in the cycle `cnt` becomes 0 after the next wrap.
  - IDLE: one cycle after the change.
- **DRAIN exit:** `run` falls in the same cycle `cnt` returns to all-ones, i.e. the cycle after the `period_end` cycle.

## Structure
- **Shared package:**
  - state encoding typedef (IDLE, RUN, DRAIN);
  - the `CNT_MAX` constant;
  - the default STEP and DUTY_RST values, reused by the top level.
- **Sub-module:** `pwm_presc`, the prescaler tick generator with clear. Everything else stays in one always-block FSM plus the shadow-register logic.

## Test plan
- **Reset and start:** reset, `en` = 1 with PRESCALE = 1 → `cnt` runs 0..1023 and wraps. `period_end` fires every 1024 cycles. `duty` = 512.
- **inc during RUN:** 3 `inc` pulses mid-period → `duty` stays 512 until the wrap, then becomes 560 exactly on the `cnt` = 0 cycle.
- **Saturation:** load 1020, then `inc` → 1023. Load 5, then `dec` → 0. Simultaneous `inc` & `dec` → no change.
- **Load handshake:** `load_valid` with 100 in RUN → accepted and `load_ready` = 0 until the wrap. A second `load_valid` with 200 is held off. `duty` = 100 after the wrap, then 200 after the following wrap.
- **Drain:** `en` falls at `cnt` = 300 → counting continues to 1023. `period_end` fires, then `run` = 0, `cnt` = 1023, `duty` = 0. `en` re-raised during DRAIN → stays in RUN with no gap.
- **Reset mid-period:** `reset` at `cnt` = 700 with a pending load → next cycle shows all reset values, `load_ready` = 1, and the pending duty is discarded.
